// File: rtl/gc_refresh_scheduler_if.sv
// rtl/gc_refresh_scheduler_if.sv - req/ack handshake between the refresh scheduler and the row refresh engine
interface gc_refresh_scheduler_if #(
  parameter int ADDR_W = 7
);
  logic              ref_req;
  logic [ADDR_W-1:0] ref_addr;
  logic              ref_ack;

  modport master (output ref_req, output ref_addr, input ref_ack);
  modport slave  (input ref_req, input ref_addr, output ref_ack);
endinterface

// File: rtl/gc_refresh_scheduler.sv
// rtl/gc_refresh_scheduler.sv - per-pass row refresh sweep with write skipping, read-miss promotion and retention timer
module gc_refresh_scheduler #(
  parameter int ADDR_W     = 7,
  parameter int RET_CYCLES = 4096,
  parameter int TMR_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   auto_en,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_fresh,
  gc_refresh_scheduler_if.master eng,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [ADDR_W:0]        ref_count
);
  localparam int                ROWS     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = {ADDR_W{1'b1}};
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(RET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEEK, REQ} state_t;

  state_t            state_q, state_d;
  logic [ROWS-1:0]   sb_q, sb_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ref_addr_q, ref_addr_d;
  logic              urg_vld_q, urg_vld_d;
  logic [ADDR_W-1:0] urg_addr_q, urg_addr_d;
  logic              urg_act_q, urg_act_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              overrun_q, overrun_d;
  logic              done_q, done_d;
  logic              rd_fresh_q, rd_fresh_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              finish;
  logic              in_pass;
  logic              tmr_hit;

  assign in_pass = (state_q != IDLE);
  assign tmr_hit = auto_en && (tmr_q == TMR_LAST);

  always_comb begin
    state_d    = state_q;
    sb_d       = sb_q;
    ptr_d      = ptr_q;
    ref_addr_d = ref_addr_q;
    urg_vld_d  = urg_vld_q;
    urg_addr_d = urg_addr_q;
    urg_act_d  = urg_act_q;
    cnt_d      = cnt_q;
    overrun_d  = overrun_q;
    done_d     = 1'b0;
    rd_fresh_d = rd_fresh_q;
    tmr_d      = tmr_q;
    finish     = 1'b0;

    if (auto_en) begin
      tmr_d = tmr_hit ? '0 : tmr_q + 1'b1;
    end
    if (tmr_hit && in_pass) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start || tmr_hit) begin
          sb_d    = '0;
          ptr_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = SEEK;
          if (start) begin
            overrun_d = 1'b0;
          end
        end
      end
      SEEK: begin
        if (urg_vld_q && !sb_q[urg_addr_q]) begin
          state_d    = REQ;
          ref_addr_d = urg_addr_q;
          urg_act_d  = 1'b1;
        end else if (urg_vld_q) begin
          urg_vld_d = 1'b0;
        end else if (sb_q[ptr_q]) begin
          if (ptr_q == LAST_ROW) begin
            finish = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
          state_d    = REQ;
          ref_addr_d = ptr_q;
          urg_act_d  = 1'b0;
        end
      end
      REQ: begin
        if (eng.ref_ack) begin
          sb_d[ref_addr_q] = 1'b1;
          cnt_d            = cnt_q + 1'b1;
          if (urg_act_q) begin
            urg_vld_d = 1'b0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
          if (!urg_act_q && (ptr_q == LAST_ROW) && !urg_vld_q) begin
            finish = 1'b1;
          end else begin
            state_d = SEEK;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Read misses are promoted only when the slot is free and the row is not already in flight.
    if (rd_en) begin
      rd_fresh_d = in_pass ? sb_q[rd_addr] : 1'b1;
      if (in_pass && !sb_q[rd_addr] && !urg_vld_q &&
          !((state_q == REQ) && (rd_addr == ref_addr_q))) begin
        urg_vld_d  = 1'b1;
        urg_addr_d = rd_addr;
      end
    end

    if (wr_en) begin
      sb_d[wr_addr] = 1'b1;
    end

    if (finish) begin
      state_d   = IDLE;
      done_d    = 1'b1;
      urg_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sb_q       <= '0;
      ptr_q      <= '0;
      ref_addr_q <= '0;
      urg_vld_q  <= 1'b0;
      urg_addr_q <= '0;
      urg_act_q  <= 1'b0;
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_fresh_q <= 1'b0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      sb_q       <= sb_d;
      ptr_q      <= ptr_d;
      ref_addr_q <= ref_addr_d;
      urg_vld_q  <= urg_vld_d;
      urg_addr_q <= urg_addr_d;
      urg_act_q  <= urg_act_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
      done_q     <= done_d;
      rd_fresh_q <= rd_fresh_d;
      tmr_q      <= tmr_d;
    end
  end

  assign eng.ref_req  = (state_q == REQ);
  assign eng.ref_addr = ref_addr_q;
  assign busy         = in_pass;
  assign done         = done_q;
  assign overrun      = overrun_q;
  assign ref_count    = cnt_q;
  assign rd_fresh     = rd_fresh_q;
endmodule

// File: tb/tb_gc_refresh_scheduler.sv
// tb/tb_gc_refresh_scheduler.sv - scoreboard bench for gc_refresh_scheduler with a behavioural pass model
module tb_gc_refresh_scheduler;
  localparam int ADDR_W     = 3;
  localparam int ROWS       = 2 ** ADDR_W;
  localparam int RET_CYCLES = 10;
  localparam int TMR_W      = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              auto_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_fresh;
  logic              busy;
  logic              done;
  logic              overrun;
  logic [ADDR_W:0]   ref_count;

  gc_refresh_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  gc_refresh_scheduler #(
    .ADDR_W(ADDR_W), .RET_CYCLES(RET_CYCLES), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_fresh(rd_fresh), .eng(bus), .busy(busy), .done(done),
    .overrun(overrun), .ref_count(ref_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: rows fresh this pass, sweep position, one-entry urgent list.
  bit  m_in_pass, m_waiting, m_serving_urgent, m_overrun;
  bit  m_fresh [ROWS];
  bit  m_fresh_pre [ROWS];
  int  m_sweep, m_row, m_refreshed, m_timer;
  int  m_urgent[$];
  bit  m_expire, m_capture, m_finish, m_pending;
  int  exp_req_q[$];
  int  exp_done_q[$];
  bit  exp_fresh_q[$];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_in_pass = 0; m_waiting = 0; m_serving_urgent = 0; m_overrun = 0;
        m_sweep = 0; m_row = 0; m_refreshed = 0; m_timer = 0;
        foreach (m_fresh[i]) m_fresh[i] = 0;
        m_urgent.delete(); exp_req_q.delete(); exp_done_q.delete(); exp_fresh_q.delete();
      end else begin
        m_fresh_pre = m_fresh;
        m_pending   = m_urgent.size() > 0;
        m_finish    = 0;
        m_capture   = rd_en && m_in_pass && !m_fresh_pre[rd_addr] && !m_pending &&
                      !(m_waiting && int'(rd_addr) == m_row);
        if (rd_en) exp_fresh_q.push_back(m_in_pass ? m_fresh_pre[rd_addr] : 1'b1);
        m_expire = auto_en && (m_timer == RET_CYCLES - 1);
        if (auto_en) m_timer = m_expire ? 0 : m_timer + 1;
        if (m_expire && m_in_pass) m_overrun = 1;
        if (!m_in_pass) begin
          if (start || m_expire) begin
            foreach (m_fresh[i]) m_fresh[i] = 0;
            m_sweep = 0; m_refreshed = 0; m_timer = 0; m_in_pass = 1;
            if (start) m_overrun = 0;
          end
        end else if (!m_waiting) begin
          if (m_pending && !m_fresh_pre[m_urgent[0]]) begin
            m_row = m_urgent[0]; m_serving_urgent = 1; m_waiting = 1;
            exp_req_q.push_back(m_row);
          end else if (m_pending) begin
            m_urgent.delete();
          end else if (m_fresh_pre[m_sweep]) begin
            if (m_sweep == ROWS - 1) m_finish = 1;
            else m_sweep++;
          end else begin
            m_row = m_sweep; m_serving_urgent = 0; m_waiting = 1;
            exp_req_q.push_back(m_row);
          end
        end else if (bus.ref_ack) begin
          m_fresh[m_row] = 1; m_refreshed++; m_waiting = 0;
          if (m_serving_urgent) begin
            m_urgent.delete();
          end else begin
            if (m_sweep == ROWS - 1 && !m_pending) m_finish = 1;
            m_sweep = (m_sweep + 1) % ROWS;
          end
        end
        if (m_capture) m_urgent.push_back(int'(rd_addr));
        if (wr_en) m_fresh[wr_addr] = 1;
        if (m_finish) begin
          m_in_pass = 0; m_waiting = 0; m_urgent.delete();
          exp_done_q.push_back(m_refreshed);
        end
      end
    end
  end

  // Monitor: pops model expectations whenever the DUT presents an event.
  bit req_prev, mon_new_req, mon_has;
  int mon_val;
  int issued[$];

  initial begin
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      check("busy", int'(busy), int'(m_in_pass));
      check("ref_req", int'(bus.ref_req), int'(m_waiting));
      check("overrun", int'(overrun), int'(m_overrun));
      mon_new_req = bus.ref_req && !req_prev;
      req_prev    = bus.ref_req;
      if (mon_new_req) issued.push_back(int'(bus.ref_addr));
      mon_has = exp_req_q.size() > 0;
      mon_val = mon_has ? exp_req_q.pop_front() : -1;
      check("req_event", int'(mon_new_req), int'(mon_has));
      if (mon_new_req && mon_has) check("ref_addr", int'(bus.ref_addr), mon_val);
      mon_has = exp_done_q.size() > 0;
      mon_val = mon_has ? exp_done_q.pop_front() : -1;
      check("done_event", int'(done), int'(mon_has));
      if (done && mon_has) check("ref_count", int'(ref_count), mon_val);
      if (exp_fresh_q.size() > 0) check("rd_fresh", int'(rd_fresh), int'(exp_fresh_q.pop_front()));
    end
  end

  // Refresh engine: acks after fixed_delay cycles of ref_req, or a random delay when negative.
  int fixed_delay = 0;
  int eng_wait, eng_delay;

  initial begin
    bus.ref_ack = 1'b0;
    eng_wait = 0; eng_delay = 0;
    forever begin
      @(negedge clk); #1;
      if (bus.ref_req && !rst) begin
        bus.ref_ack = (eng_wait >= eng_delay);
        eng_wait++;
      end else begin
        bus.ref_ack = 1'b0;
        eng_wait    = 0;
        eng_delay   = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end
    end
  end

  int n;
  bit seen_ovr;
  int exp_seq[$];

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start();
    issued.delete();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_issued(input int k);
    n = 0;
    while (issued.size() < k && n < 200) begin tick(); n++; end
    check("wait_req", int'(issued.size() >= k), 1);
  endtask

  task automatic wait_done(input string name);
    n = 0;
    while (!done && n < 400) begin tick(); n++; end
    check({name, "_done"}, int'(done), 1);
  endtask

  task automatic check_seq(input string name);
    check({name, "_len"}, issued.size(), exp_seq.size());
    foreach (exp_seq[i]) check(name, (i < issued.size()) ? issued[i] : -1, exp_seq[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; auto_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_ref_req", int'(bus.ref_req), 0);
    check("rst_ref_addr", int'(bus.ref_addr), 0);
    check("rst_done", int'(done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_ref_count", int'(ref_count), 0);
    check("rst_rd_fresh", int'(rd_fresh), 0);
    rst = 1'b0;
    tick();

    // Full sweep with immediate ack
    fixed_delay = 0;
    pulse_start();
    n = 1;
    while (!done && n < 100) begin tick(); n++; end
    check("t1_done_latency", n, 17);
    check("t1_ref_count", int'(ref_count), 8);
    exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_seq("t1_seq");
    tick();
    check("t1_done_one_cycle", int'(done), 0);
    rd_en = 1'b1; rd_addr = 3'd3; tick(); rd_en = 1'b0;
    check("t1_rd_fresh_idle", int'(rd_fresh), 1);

    // Rows written early in the pass are skipped
    pulse_start();
    wr_en = 1'b1; wr_addr = 3'd2; tick();
    wr_addr = 3'd5; tick(); wr_en = 1'b0;
    wait_done("t2");
    check("t2_ref_count", int'(ref_count), 6);
    exp_seq = '{0, 1, 3, 4, 6, 7};
    check_seq("t2_seq");

    // Read miss promoted to urgent refresh
    fixed_delay = 3;
    pulse_start();
    wait_issued(2);
    rd_en = 1'b1; rd_addr = 3'd6; tick(); rd_en = 1'b0;
    check("t3_rd_miss", int'(rd_fresh), 0);
    wait_done("t3");
    check("t3_ref_count", int'(ref_count), 8);
    exp_seq = '{0, 1, 6, 2, 3, 4, 5, 7};
    check_seq("t3_seq");

    // Second miss while the slot is occupied is not captured
    pulse_start();
    wait_issued(2);
    rd_en = 1'b1; rd_addr = 3'd4; tick();
    check("t4_rd_miss4", int'(rd_fresh), 0);
    rd_addr = 3'd7; tick(); rd_en = 1'b0;
    check("t4_rd_miss7", int'(rd_fresh), 0);
    wait_done("t4");
    exp_seq = '{0, 1, 4, 2, 3, 5, 6, 7};
    check_seq("t4_seq");

    // Auto mode overrun and clearing by start
    fixed_delay = 5;
    auto_en = 1'b1;
    n = 0;
    while (!busy && n < 40) begin tick(); n++; end
    check("t5_auto_start", int'(busy), 1);
    seen_ovr = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      if (overrun) seen_ovr = 1'b1;
      tick(); n++;
    end
    auto_en = 1'b0;
    check("t5_overrun_seen", int'(seen_ovr), 1);
    tick(); tick();
    check("t5_overrun_sticky", int'(overrun), 1);
    fixed_delay = 0;
    pulse_start();
    check("t5_overrun_cleared", int'(overrun), 0);
    wait_done("t5");

    // Asynchronous reset in the middle of a request
    fixed_delay = 3;
    pulse_start();
    wait_issued(1);
    rst = 1'b1; #1;
    check("t6_rst_ref_req", int'(bus.ref_req), 0);
    check("t6_rst_busy", int'(busy), 0);
    tick(); rst = 1'b0; tick();
    pulse_start();
    wait_issued(1);
    check("t6_first_row", (issued.size() > 0) ? issued[0] : -1, 0);
    wait_done("t6");

    // Randomized traffic against the model
    fixed_delay = -1;
    for (int c = 0; c < 3000; c++) begin
      start   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_addr = ADDR_W'($urandom_range(0, ROWS - 1));
      rd_en   = ($urandom_range(0, 3) == 0);
      rd_addr = ADDR_W'($urandom_range(0, ROWS - 1));
      tick();
    end
    start = 1'b0; auto_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    n = 0;
    while (busy && n < 400) begin tick(); n++; end
    check("drain_busy", int'(busy), 0);
    tick(); tick();
    check("events_pending", exp_req_q.size() + exp_done_q.size() + exp_fresh_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
